// File: rtl/btb_ctrl.sv
// Direct-mapped branch target buffer. One array port is shared between fetch
// lookups and a queued read-modify-write updater fed by resolved branches.
module btb_ctrl #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned QDEPTH  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] predicted_PC,
    output logic        stallbp,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_pc,
    input  logic [31:0] res_target,
    input  logic        res_taken,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic        flushbp,
    output logic [31:0] correct_PC,
    output logic [15:0] mispred_cnt
);
    localparam int unsigned IDXW = $clog2(ENTRIES);
    localparam int unsigned TAGW = 30 - IDXW;
    localparam int unsigned CNTW = $clog2(QDEPTH + 1);
    localparam int unsigned PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } upd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } upd_state_t;

    logic            ent_v   [ENTRIES];
    logic [TAGW-1:0] ent_tag [ENTRIES];
    logic [31:0]     ent_tgt [ENTRIES];
    logic [1:0]      ent_ctr [ENTRIES];

    upd_t            fifo_q [QDEPTH];
    logic [PTRW-1:0] wr_ptr_q;
    logic [PTRW-1:0] rd_ptr_q;
    logic [CNTW-1:0] count_q;

    upd_state_t      state_q;
    logic            upd_hit_q;
    logic [1:0]      upd_ctr_q;

    logic            full_c;
    logic            lookup_gnt_c;
    logic            upd_gnt_c;
    upd_t            head_c;
    logic [IDXW-1:0] head_idx_c;
    logic [TAGW-1:0] head_tag_c;
    logic [IDXW-1:0] if_idx_c;
    logic [TAGW-1:0] if_tag_c;
    logic [IDXW-1:0] port_idx_c;
    logic            port_hit_c;
    logic [1:0]      port_ctr_c;
    logic [31:0]     port_tgt_c;
    logic            rd_fire_c;
    logic            wr_fire_c;
    logic            deq_c;
    logic            enq_c;
    logic            mispred_c;
    logic [1:0]      ctr_nxt_c;
    logic            unused_bits_c;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(QDEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    assign unused_bits_c = ^{if_pc[1:0], head_c.pc[1:0]};

    // Port arbitration: lookups own the port unless the queue is full.
    always_comb begin
        full_c       = (count_q == CNTW'(QDEPTH));
        lookup_gnt_c = if_valid & ~full_c;
        upd_gnt_c    = ~lookup_gnt_c;
        head_c       = fifo_q[rd_ptr_q];
        head_idx_c   = head_c.pc[IDXW+1:2];
        head_tag_c   = head_c.pc[31:IDXW+2];
        if_idx_c     = if_pc[IDXW+1:2];
        if_tag_c     = if_pc[31:IDXW+2];
        port_idx_c   = lookup_gnt_c ? if_idx_c : head_idx_c;
        port_hit_c   = ent_v[port_idx_c] &&
                       (ent_tag[port_idx_c] == (lookup_gnt_c ? if_tag_c : head_tag_c));
        port_ctr_c   = ent_ctr[port_idx_c];
        port_tgt_c   = ent_tgt[port_idx_c];
    end

    always_comb begin
        pred_taken   = lookup_gnt_c & port_hit_c & port_ctr_c[1];
        predicted_PC = pred_taken ? port_tgt_c : if_pc + 32'd4;
        stallbp      = if_valid & full_c;
    end

    // Dequeue happens on a granted WR, or on a granted RD that needs no write.
    always_comb begin
        rd_fire_c = (state_q == RD) & upd_gnt_c;
        wr_fire_c = (state_q == WR) & upd_gnt_c;
        deq_c     = wr_fire_c | (rd_fire_c & ~port_hit_c & ~head_c.taken);
        res_ready = ~full_c | deq_c;
        enq_c     = res_valid & res_ready;
        mispred_c = (res_taken != res_pred_taken) |
                    (res_taken & (res_target != res_pred_target));
    end

    always_comb begin
        ctr_nxt_c = upd_ctr_q;
        if (head_c.taken) begin
            if (upd_ctr_q != 2'b11) ctr_nxt_c = upd_ctr_q + 2'd1;
        end else begin
            if (upd_ctr_q != 2'b00) ctr_nxt_c = upd_ctr_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            upd_hit_q <= 1'b0;
            upd_ctr_q <= 2'b01;
        end else begin
            case (state_q)
                IDLE: if (count_q != '0) state_q <= RD;
                RD: if (upd_gnt_c) begin
                    upd_hit_q <= port_hit_c;
                    upd_ctr_q <= port_ctr_c;
                    state_q   <= (port_hit_c | head_c.taken) ? WR : IDLE;
                end
                WR: if (upd_gnt_c) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ent_v[i]   <= 1'b0;
                ent_ctr[i] <= 2'b01;
            end
        end else if (wr_fire_c) begin
            ent_v[head_idx_c]   <= 1'b1;
            ent_ctr[head_idx_c] <= upd_hit_q ? ctr_nxt_c : 2'b10;
        end
    end

    // Tag/target carry no reset; the reset gate keeps a reset cycle write-free.
    always_ff @(posedge clk) begin
        if (resetn && wr_fire_c) begin
            if (!upd_hit_q) ent_tag[head_idx_c] <= head_tag_c;
            if (!upd_hit_q || head_c.taken) ent_tgt[head_idx_c] <= head_c.target;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (deq_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (enq_c && !deq_c) count_q <= count_q + CNTW'(1);
            else if (deq_c && !enq_c) count_q <= count_q - CNTW'(1);
        end
    end

    // When full, the enqueue slot equals the head being retired this cycle.
    always_ff @(posedge clk) begin
        if (enq_c) fifo_q[wr_ptr_q] <= '{pc: res_pc, target: res_target, taken: res_taken};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            flushbp     <= 1'b0;
            correct_PC  <= 32'd0;
            mispred_cnt <= 16'd0;
        end else begin
            flushbp <= enq_c & mispred_c;
            if (enq_c && mispred_c) begin
                correct_PC <= res_taken ? res_target : res_pc + 32'd4;
                if (mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
            end
        end
    end

endmodule
